mem_fifo: RTL and testbench

Parametrised successor to the single-register storage element. It buffers DATA_WIDTH-bit words in a DEPTH-entry synchronous FIFO with write/read enables, a registered read port and occupancy count. It adds status flags, sticky error flags and a synchronous flush. It sits between a producer and a consumer running on the same clock.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_fifo_if.sv | 29 ++
 rtl/mem_array.sv | 25 ++
 rtl/mem_fifo.sv | 87 ++++++++
 tb/tb_mem_fifo.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared sizing helpers for the mem_fifo block.
// Depth and count width are derived from the pointer width.
package mem_pkg;

  localparam int DATA_WIDTH_DEF = 3;
  localparam int ADDR_WIDTH_DEF = 2;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // The count needs one extra bit so that it can hold DEPTH itself.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/mem_fifo_if.sv
// Producer/consumer bus of mem_fifo.
// The master modport drives requests; the slave (the FIFO) drives data and status.
interface mem_fifo_if #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 2
);
  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] out;
  logic                  out_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr_en, in, rd_en,
    input  out, out_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, in, rd_en,
    output out, out_valid, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read address.
// Contents are deliberately not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_fifo.sv
// Synchronous FIFO with registered read port, occupancy count, status decodes,
// sticky overflow/underflow flags and a synchronous flush.
module mem_fifo
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AFULL_TH   = 3
) (
  input  logic       clk,
  input  logic       rst,
  mem_fifo_if.slave  bus
);
  localparam int             DEPTH   = depth_of(ADDR_WIDTH);
  localparam int             CW      = cnt_w(ADDR_WIDTH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  AFULL_C = CW'(AFULL_TH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] out_q, rdata;
  logic                  out_valid_q, ovf_q, udf_q;
  logic                  full, empty;
  logic                  rd_acc, wr_acc;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A read frees the head slot on the same edge, so a full FIFO may still
  // accept a write when a read is also accepted. Flush masks both requests.
  assign rd_acc = ~bus.clr & bus.rd_en & ~empty;
  assign wr_acc = ~bus.clr & bus.wr_en & (~full | rd_acc);

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      out_valid_q <= rd_acc;
      if (rd_acc) begin
        out_q  <= rdata;
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.wr_en & full & ~rd_acc) ovf_q <= 1'b1;
      if (bus.rd_en & empty)          udf_q <= 1'b1;
    end
  end

  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.count       = count;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (count >= AFULL_C);
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
endmodule

// File: tb/tb_mem_fifo.sv
// Directed bench for mem_fifo: a queue model checked every cycle on the falling
// edge, plus literal expectations from the test plan sampled just after edges.
module tb_mem_fifo;
  localparam int DW = 3;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AFT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(AFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of stored words plus the registered outputs.
  logic [DW-1:0] q[$];
  int  m_out = 0;
  bit  m_vld = 0, m_ovf = 0, m_udf = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_out = 0; m_vld = 0; m_ovf = 0; m_udf = 0;
    end else if (bus.clr) begin
      q.delete();
      m_vld = 0; m_ovf = 0; m_udf = 0;
    end else begin
      bit can_rd, can_wr;
      can_rd = bus.rd_en && (q.size() > 0);
      can_wr = bus.wr_en && ((q.size() < DEPTH) || can_rd);
      if (can_rd) m_out = int'(q.pop_front());
      m_vld = can_rd;
      if (can_wr) q.push_back(bus.in);
      if (bus.wr_en && !can_wr) m_ovf = 1;
      if (bus.rd_en && !can_rd) m_udf = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out",   int'(bus.out),         m_out);
      chk("m_vld",   int'(bus.out_valid),   int'(m_vld));
      chk("m_count", int'(bus.count),       q.size());
      chk("m_full",  int'(bus.full),        int'(q.size() == DEPTH));
      chk("m_empty", int'(bus.empty),       int'(q.size() == 0));
      chk("m_afull", int'(bus.almost_full), int'(q.size() >= AFT));
      chk("m_ovf",   int'(bus.overflow),    int'(m_ovf));
      chk("m_udf",   int'(bus.underflow),   int'(m_udf));
    end
  end

  task automatic cyc(input bit w, input int d, input bit r, input bit c);
    bus.wr_en = w;
    bus.in    = DW'(d);
    bus.rd_en = r;
    bus.clr   = c;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic fill4(input int a, input int b, input int c, input int d);
    cyc(1, a, 0, 0);
    cyc(1, b, 0, 0);
    cyc(1, c, 0, 0);
    cyc(1, d, 0, 0);
  endtask

  task automatic rd_exp(input string nm, input int exp);
    cyc(0, 0, 1, 0);
    chk(nm, int'(bus.out), exp);
    chk({nm, "_vld"}, int'(bus.out_valid), 1);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr = 1'b0; bus.in = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full",  int'(bus.full), 0);
    chk("rst_out",   int'(bus.out), 0);
    chk("rst_vld",   int'(bus.out_valid), 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // 1: fill
    cyc(1, 3'b010, 0, 0); chk("t1_cnt1", int'(bus.count), 1); chk("t1_af1", int'(bus.almost_full), 0);
    cyc(1, 3'b111, 0, 0); chk("t1_cnt2", int'(bus.count), 2); chk("t1_af2", int'(bus.almost_full), 0);
    cyc(1, 3'b100, 0, 0); chk("t1_cnt3", int'(bus.count), 3); chk("t1_af3", int'(bus.almost_full), 1);
    cyc(1, 3'b001, 0, 0); chk("t1_cnt4", int'(bus.count), 4);
    chk("t1_full", int'(bus.full), 1); chk("t1_empty", int'(bus.empty), 0);

    // 2: drain
    rd_exp("t2_r0", 3'b010); rd_exp("t2_r1", 3'b111);
    rd_exp("t2_r2", 3'b100); rd_exp("t2_r3", 3'b001);
    chk("t2_empty", int'(bus.empty), 1); chk("t2_udf", int'(bus.underflow), 0);
    cyc(0, 0, 0, 0);
    chk("t2_hold", int'(bus.out), 3'b001); chk("t2_vld0", int'(bus.out_valid), 0);

    // 3: refused write when full
    fill4(3'b010, 3'b111, 3'b100, 3'b001);
    cyc(1, 3'b110, 0, 0);
    chk("t3_ovf", int'(bus.overflow), 1); chk("t3_cnt", int'(bus.count), 4);
    rd_exp("t3_r0", 3'b010); rd_exp("t3_r1", 3'b111);
    rd_exp("t3_r2", 3'b100); rd_exp("t3_r3", 3'b001);
    chk("t3_empty", int'(bus.empty), 1); chk("t3_ovf_sticky", int'(bus.overflow), 1);
    cyc(0, 0, 0, 1);
    chk("t3_clr_ovf", int'(bus.overflow), 0);

    // 4: simultaneous read/write when full, then drain across the wrap
    fill4(3'b010, 3'b111, 3'b100, 3'b001);
    cyc(1, 3'b110, 1, 0);
    chk("t4_out", int'(bus.out), 3'b010); chk("t4_cnt", int'(bus.count), 4);
    chk("t4_ovf", int'(bus.overflow), 0);
    rd_exp("t4_r0", 3'b111); rd_exp("t4_r1", 3'b100);
    rd_exp("t4_r2", 3'b001); rd_exp("t4_r3", 3'b110);

    // 5: simultaneous read/write when empty
    cyc(1, 3'b101, 1, 0);
    chk("t5_udf", int'(bus.underflow), 1); chk("t5_cnt", int'(bus.count), 1);
    chk("t5_vld", int'(bus.out_valid), 0);
    rd_exp("t5_r0", 3'b101);

    // 6: async reset with 2 entries and overflow set, then flush vs write
    cyc(0, 0, 0, 1);
    fill4(3'b011, 3'b010, 3'b001, 3'b100);
    cyc(1, 3'b111, 0, 0);
    rd_exp("t6_r0", 3'b011); rd_exp("t6_r1", 3'b010);
    chk("t6_cnt2", int'(bus.count), 2); chk("t6_ovf", int'(bus.overflow), 1);
    #1 rst = 1'b0;
    #2;
    chk("t6_arst_out",   int'(bus.out), 0);
    chk("t6_arst_cnt",   int'(bus.count), 0);
    chk("t6_arst_empty", int'(bus.empty), 1);
    chk("t6_arst_ovf",   int'(bus.overflow), 0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    cyc(1, 3'b110, 0, 0);
    cyc(1, 3'b101, 0, 0);
    chk("t6_cnt_pre", int'(bus.count), 2);
    cyc(1, 3'b111, 0, 1);
    chk("t6_clr_cnt", int'(bus.count), 0); chk("t6_clr_empty", int'(bus.empty), 1);
    cyc(0, 0, 1, 0);
    chk("t6_clr_udf", int'(bus.underflow), 1); chk("t6_clr_vld", int'(bus.out_valid), 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
